// File: rtl/traffic_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_gen_pkg
// Description : Shared types, LFSR step and destination helpers for the
//               flit-level traffic generator.
// Revision    : 1.0
// ============================================================================
package traffic_gen_pkg;

    typedef enum logic [1:0] {
        MODE_UNIFORM   = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_BITCOMP   = 2'd2,
        MODE_HOTSPOT   = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [31:0] C_LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] C_SEED_STRIDE = 32'h9E37_79B9;

    localparam int C_OFF_STAMP = 0;
    localparam int C_OFF_IDX   = 16;
    localparam int C_OFF_SEQ   = 32;
    localparam int C_OFF_DEST  = 48;
    localparam int C_OFF_SRC   = 56;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? C_LFSR_POLY : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] node_seed(input logic [31:0] base,
                                              input logic [31:0] node);
        logic [31:0] v;
        v = base ^ (node * C_SEED_STRIDE);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic logic [7:0] calc_dest(input mode_t       mode,
                                             input logic [7:0]  node,
                                             input logic [7:0]  rnd,
                                             input logic [7:0]  hotspot,
                                             input logic [7:0]  mask,
                                             input int unsigned half);
        logic [7:0] lo_mask;
        logic [7:0] d;
        lo_mask = ~(8'hFF << half);
        case (mode)
            MODE_UNIFORM:   d = rnd;
            MODE_TRANSPOSE: d = ((node & lo_mask) << half) | (node >> half);
            MODE_BITCOMP:   d = ~node;
            default:        d = hotspot;
        endcase
        return d & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_gen_chan.sv
`default_nettype none
// ============================================================================
// Module      : traffic_gen_chan
// Description : One injection node: LFSR, pending-packet counter, IDLE/SEND
//               flit FSM and packet/drop counters.
// Revision    : 1.0
// ============================================================================
module traffic_gen_chan
    import traffic_gen_pkg::*;
#(
    parameter int N         = 16,
    parameter int WIDTH     = 128,
    parameter int MIN_FLITS = 1,
    parameter int LEN_MASK  = 3,
    parameter int QDEPTH    = 8,
    parameter int SEED      = 1,
    parameter int NODE_ID   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [15:0]      i_rate,
    input  logic [1:0]       i_mode,
    input  logic [7:0]       i_hotspot,
    input  logic [15:0]      i_stamp,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_head,
    output logic             o_tail,
    output logic [7:0]       o_dest,
    output logic [WIDTH-1:0] o_data,
    output logic [31:0]      o_pkt_count,
    output logic [31:0]      o_drop_count
);

    localparam int          LOG2N       = $clog2(N);
    localparam int unsigned HALF        = LOG2N / 2;
    localparam int          QW          = $clog2(QDEPTH + 1);
    localparam logic [7:0]  C_NODE_MASK = 8'(N - 1);
    localparam logic [7:0]  C_NODE_ID   = 8'(NODE_ID);
    localparam logic [31:0] C_SEED      = node_seed(32'(SEED), 32'(NODE_ID));
    localparam logic [QW-1:0] C_QDEPTH  = QW'(QDEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_lfsr;
    logic [QW-1:0] r_pending;
    logic          r_valid;
    logic          r_head;
    logic          r_tail;
    logic [7:0]    r_src;
    logic [7:0]    r_dest;
    logic [15:0]   r_len;
    logic [15:0]   r_idx;
    logic [15:0]   r_seq;
    logic [15:0]   r_seq_out;
    logic [15:0]   r_stamp;
    logic [31:0]   r_pkt_count;
    logic [31:0]   r_drop_count;

    logic          w_xfer;
    logic          w_tail_xfer;
    logic          w_pend_nz;
    logic          w_start;
    logic          w_advance;
    logic          w_draw;
    logic          w_accept;
    logic          w_drop;
    logic [7:0]    w_dest;
    logic [15:0]   w_len;
    logic [63:0]   w_payload;

    assign w_xfer      = r_valid & i_ready;
    assign w_tail_xfer = w_xfer & r_tail;
    assign w_pend_nz   = (r_pending != '0);

    assign w_dest = calc_dest(mode_t'(i_mode), C_NODE_ID, r_lfsr[23:16],
                              i_hotspot, C_NODE_MASK, HALF);
    assign w_len  = 16'(MIN_FLITS) + {8'h00, r_lfsr[31:24] & 8'(LEN_MASK)};

    // A full queue still accepts a draw when a packet starts on the same edge.
    assign w_draw   = i_enable && (r_lfsr[15:0] < i_rate);
    assign w_accept = w_draw && ((r_pending < C_QDEPTH) || w_start);
    assign w_drop   = w_draw && !w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pend_nz) w_state_nxt = ST_SEND;
            ST_SEND: if (w_tail_xfer && !w_pend_nz) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: w_start = w_pend_nz;
            ST_SEND: begin
                w_start   = w_tail_xfer && w_pend_nz;
                w_advance = w_xfer && !r_tail;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr       <= C_SEED;
            r_pending    <= '0;
            r_valid      <= 1'b0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_src        <= 8'h00;
            r_dest       <= 8'h00;
            r_len        <= 16'h0;
            r_idx        <= 16'h0;
            r_seq        <= 16'h0;
            r_seq_out    <= 16'h0;
            r_stamp      <= 16'h0;
            r_pkt_count  <= 32'h0;
            r_drop_count <= 32'h0;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);

            if (w_accept && !w_start) begin
                r_pending <= r_pending + 1'b1;
            end else if (!w_accept && w_start) begin
                r_pending <= r_pending - 1'b1;
            end

            if (w_drop)      r_drop_count <= r_drop_count + 32'd1;
            if (w_tail_xfer) r_pkt_count  <= r_pkt_count + 32'd1;

            if (w_start) begin
                r_valid   <= 1'b1;
                r_head    <= 1'b1;
                r_tail    <= (w_len == 16'd1);
                r_src     <= C_NODE_ID;
                r_dest    <= w_dest;
                r_len     <= w_len;
                r_idx     <= 16'h0;
                r_seq_out <= r_seq;
                r_seq     <= r_seq + 16'd1;
                r_stamp   <= i_stamp;
            end else if (w_advance) begin
                r_head <= 1'b0;
                r_idx  <= r_idx + 16'd1;
                r_tail <= ((r_idx + 16'd2) == r_len);
            end else if (w_tail_xfer) begin
                r_valid <= 1'b0;
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
            end
        end
    end

    assign w_payload = {r_src, r_dest, r_seq_out, r_idx, r_stamp};

    generate
        if (WIDTH > 64) begin : g_pad
            assign o_data = {{(WIDTH - 64){1'b0}}, w_payload};
        end else begin : g_nopad
            assign o_data = w_payload;
        end
    endgenerate

    assign o_valid      = r_valid;
    assign o_head       = r_head;
    assign o_tail       = r_tail;
    assign o_dest       = r_dest;
    assign o_pkt_count  = r_pkt_count;
    assign o_drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: rtl/traffic_gen_flit.sv
`default_nettype none
// ============================================================================
// Module      : traffic_gen_flit
// Description : N-node flit traffic generator; fans shared controls and the
//               global cycle stamp out to one channel per injection port.
// Revision    : 1.0
// ============================================================================
module traffic_gen_flit
    import traffic_gen_pkg::*;
#(
    parameter int N         = 16,
    parameter int WIDTH     = 128,
    parameter int MIN_FLITS = 1,
    parameter int LEN_MASK  = 3,
    parameter int QDEPTH    = 8,
    parameter int SEED      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_enable,
    input  logic [15:0]               i_rate,
    input  logic [1:0]                i_mode,
    input  logic [7:0]                i_hotspot,
    input  logic [N-1:0]              i_ready,
    output logic [N-1:0]              o_valid,
    output logic [N-1:0]              o_head,
    output logic [N-1:0]              o_tail,
    output logic [N-1:0][7:0]         o_dest,
    output logic [N-1:0][WIDTH-1:0]   o_data,
    output logic [N-1:0][31:0]        o_pkt_count,
    output logic [N-1:0][31:0]        o_drop_count
);

    logic [15:0] r_cycle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= 16'h0;
        end else begin
            r_cycle <= r_cycle + 16'd1;
        end
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_chan
            traffic_gen_chan #(
                .N         (N),
                .WIDTH     (WIDTH),
                .MIN_FLITS (MIN_FLITS),
                .LEN_MASK  (LEN_MASK),
                .QDEPTH    (QDEPTH),
                .SEED      (SEED),
                .NODE_ID   (g)
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .i_enable     (i_enable),
                .i_rate       (i_rate),
                .i_mode       (i_mode),
                .i_hotspot    (i_hotspot),
                .i_stamp      (r_cycle),
                .i_ready      (i_ready[g]),
                .o_valid      (o_valid[g]),
                .o_head       (o_head[g]),
                .o_tail       (o_tail[g]),
                .o_dest       (o_dest[g]),
                .o_data       (o_data[g]),
                .o_pkt_count  (o_pkt_count[g]),
                .o_drop_count (o_drop_count[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_traffic_gen_flit.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_gen_flit
// Description : Directed self-checking bench for traffic_gen_flit (2-flit packets).
// Revision    : 1.0
// ============================================================================
module tb_traffic_gen_flit;

    localparam int N         = 16;
    localparam int WIDTH     = 128;
    localparam int MIN_FLITS = 2;
    localparam int LEN_MASK  = 0;
    localparam int QDEPTH    = 4;
    localparam int SEED      = 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    i_enable;
    logic [15:0]             i_rate;
    logic [1:0]              i_mode;
    logic [7:0]              i_hotspot;
    logic [N-1:0]            i_ready;
    logic [N-1:0]            o_valid;
    logic [N-1:0]            o_head;
    logic [N-1:0]            o_tail;
    logic [N-1:0][7:0]       o_dest;
    logic [N-1:0][WIDTH-1:0] o_data;
    logic [N-1:0][31:0]      o_pkt_count;
    logic [N-1:0][31:0]      o_drop_count;

    int n_cmp = 0;
    int n_err = 0;

    traffic_gen_flit #(
        .N(N), .WIDTH(WIDTH), .MIN_FLITS(MIN_FLITS),
        .LEN_MASK(LEN_MASK), .QDEPTH(QDEPTH), .SEED(SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_rate       (i_rate),
        .i_mode       (i_mode),
        .i_hotspot    (i_hotspot),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_head       (o_head),
        .o_tail       (o_tail),
        .o_dest       (o_dest),
        .o_data       (o_data),
        .o_pkt_count  (o_pkt_count),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_head(input int node, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_valid[node] && o_head[node]) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit          ok;
        bit          seen;
        logic [63:0] sum;
        logic [63:0] cap;
        logic [31:0] drops;

        reset     = 1'b1;
        i_enable  = 1'b0;
        i_rate    = 16'h0;
        i_mode    = 2'd0;
        i_hotspot = 8'h00;
        i_ready   = '1;

        // Reset state
        #12;
        check("rst_valid", 64'(o_valid), 64'h0);
        check("rst_data0", o_data[0][63:0], 64'h0);
        check("rst_pkt0", 64'(o_pkt_count[0]), 64'h0);
        check("rst_drop15", 64'(o_drop_count[15]), 64'h0);

        // Zero rate never injects
        @(negedge clk);
        reset    = 1'b0;
        i_enable = 1'b1;
        seen     = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (o_valid != '0) seen = 1'b1;
        end
        sum = 64'h0;
        for (int n = 0; n < N; n++) sum = sum + 64'(o_pkt_count[n]) + 64'(o_drop_count[n]);
        check("rate0_valid", 64'(seen), 64'h0);
        check("rate0_counts", sum, 64'h0);

        // Bit-complement destinations, 2-flit packets, back-to-back heads
        i_mode = 2'd2;
        i_rate = 16'hFFFF;
        wait_head(3, ok);
        check("bc_head_found", 64'(ok), 64'h1);
        check("bc_dest3", 64'(o_dest[3]), 64'd12);
        check("bc_src_field", 64'(o_data[3][63:56]), 64'd3);
        check("bc_dest_field", 64'(o_data[3][55:48]), 64'd12);
        check("bc_seq0", 64'(o_data[3][47:32]), 64'd0);
        check("bc_idx0", 64'(o_data[3][31:16]), 64'd0);
        check("bc_tail_on_head", 64'(o_tail[3]), 64'h0);
        check("bc_upper_zero", o_data[3][127:64], 64'h0);
        @(negedge clk);
        check("bc_flit1_vht", 64'({o_valid[3], o_head[3], o_tail[3]}), 64'b101);
        check("bc_idx1", 64'(o_data[3][31:16]), 64'd1);
        @(negedge clk);
        check("bc_nobubble", 64'({o_valid[3], o_head[3], o_tail[3]}), 64'b110);
        check("bc_seq1", 64'(o_data[3][47:32]), 64'd1);
        check("bc_pkt3", 64'(o_pkt_count[3]), 64'd1);
        check("bc_node0", 64'({o_valid[0], o_dest[0]}), 64'({1'b1, 8'd15}));

        // Backpressure on node 0 while a head is presented
        wait_head(0, ok);
        check("stall_head_found", 64'(ok), 64'h1);
        i_ready[0] = 1'b0;
        cap = o_data[0][63:0];
        repeat (20) begin
            @(negedge clk);
            check("stall_vd", 64'({o_valid[0], o_head[0], o_dest[0]}), 64'({2'b11, 8'd15}));
            check("stall_data", o_data[0][63:0], cap);
        end
        i_ready[0] = 1'b1;
        @(negedge clk);
        check("release_ht", 64'({o_valid[0], o_head[0], o_tail[0]}), 64'b101);
        check("release_idx", 64'(o_data[0][31:16]), 64'd1);
        check("release_seq", 64'(o_data[0][47:32]), 64'(cap[47:32]));

        // Transpose: 1 -> 4, 6 -> 9 ; hotspot 0xA7 -> 7
        i_mode = 2'd1;
        repeat (3) @(negedge clk);
        wait_head(1, ok);
        check("tr_dest1", 64'({ok, o_dest[1]}), 64'({1'b1, 8'd4}));
        wait_head(6, ok);
        check("tr_dest6", 64'({ok, o_dest[6]}), 64'({1'b1, 8'd9}));
        i_mode    = 2'd3;
        i_hotspot = 8'hA7;
        repeat (3) @(negedge clk);
        wait_head(2, ok);
        check("hs_dest2", 64'({ok, o_dest[2]}), 64'({1'b1, 8'd7}));

        // Asynchronous reset mid-stream
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(o_valid), 64'h0);
        check("arst_pkt3", 64'(o_pkt_count[3]), 64'h0);
        check("arst_data0", o_data[0][63:0], 64'h0);

        // Queue saturation under full backpressure
        @(negedge clk);
        i_ready = '0;
        i_mode  = 2'd0;
        reset   = 1'b0;
        repeat (40) @(negedge clk);
        check("sat_pkt5", 64'(o_pkt_count[5]), 64'h0);
        check("sat_drops", 64'((o_drop_count[5] >= 32'd30) && (o_drop_count[5] <= 32'd40)), 64'h1);
        check("sat_presented", 64'({o_valid[5], o_head[5]}), 64'b11);
        i_ready = '1;
        @(negedge clk);
        @(negedge clk);
        check("sat_first_done", 64'(o_pkt_count[5]), 64'd1);

        // Disable: queued packets (presented one + 4 pending) still drain
        i_enable = 1'b0;
        repeat (30) @(negedge clk);
        check("drain_idle", 64'(o_valid[5]), 64'h0);
        check("drain_pkt5", 64'(o_pkt_count[5]), 64'd6);
        drops = o_drop_count[5];
        repeat (10) @(negedge clk);
        check("disabled_nodrop", 64'(o_drop_count[5]), 64'(drops));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
